// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with shadowed period/high-phase settings.
// Settings change only at period boundaries; i_sync realigns all running channels.
module clk_div_multi #(
    parameter int NUM_CH    = 4,
    parameter int DIV_WIDTH = 16,
    parameter int DEF_DIV   = 4,
    parameter int DEF_HIGH  = 2
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_CH-1:0]             i_en,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   i_div,
    input  logic [NUM_CH*DIV_WIDTH-1:0]   i_high,
    input  logic                          i_load,
    input  logic                          i_sync,
    output logic [NUM_CH-1:0]             o_clk,
    output logic [NUM_CH-1:0]             o_rise,
    output logic [NUM_CH-1:0]             o_pending
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    function automatic logic [DIV_WIDTH-1:0] clamp_div(
        input logic [DIV_WIDTH-1:0] d
    );
        return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] clamp_high(
        input logic [DIV_WIDTH-1:0] d,
        input logic [DIV_WIDTH-1:0] h
    );
        logic [DIV_WIDTH-1:0] dc;
        logic [DIV_WIDTH-1:0] hc;
        dc = clamp_div(d);
        hc = (h == '0) ? DIV_WIDTH'(1) : h;
        if (hc >= dc) hc = dc - DIV_WIDTH'(1);
        return hc;
    endfunction

    localparam logic [DIV_WIDTH-1:0] RST_DIV  = clamp_div(DIV_WIDTH'(DEF_DIV));
    localparam logic [DIV_WIDTH-1:0] RST_HIGH =
        clamp_high(DIV_WIDTH'(DEF_DIV), DIV_WIDTH'(DEF_HIGH));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t               state, state_nx;
        logic [DIV_WIDTH-1:0] cnt, cnt_nx;
        logic [DIV_WIDTH-1:0] d_act, d_act_nx;
        logic [DIV_WIDTH-1:0] h_act, h_act_nx;
        logic [DIV_WIDTH-1:0] d_sh, h_sh;
        logic [DIV_WIDTH-1:0] d_in, h_in;
        logic                 pend, pend_nx;
        logic                 clk_q, clk_nx;
        logic                 rise_q, rise_nx;
        logic                 wrap, restart, stop;

        assign d_in = clamp_div(i_div[k*DIV_WIDTH +: DIV_WIDTH]);
        assign h_in = clamp_high(i_div[k*DIV_WIDTH +: DIV_WIDTH],
                                 i_high[k*DIV_WIDTH +: DIV_WIDTH]);
        assign wrap = (cnt == d_act - ONE);

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                state  <= S_IDLE;
                cnt    <= '0;
                d_act  <= RST_DIV;
                h_act  <= RST_HIGH;
                d_sh   <= RST_DIV;
                h_sh   <= RST_HIGH;
                pend   <= 1'b0;
                clk_q  <= 1'b0;
                rise_q <= 1'b0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                d_act  <= d_act_nx;
                h_act  <= h_act_nx;
                pend   <= pend_nx;
                clk_q  <= clk_nx;
                rise_q <= rise_nx;
                if (i_load) begin
                    d_sh <= d_in;
                    h_sh <= h_in;
                end
            end
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            d_act_nx = d_act;
            h_act_nx = h_act;
            pend_nx  = pend;
            clk_nx   = clk_q;
            rise_nx  = 1'b0;
            restart  = 1'b0;
            stop     = 1'b0;
            unique case (state)
                S_IDLE: restart = i_en[k];
                S_RUN, S_DRAIN: begin
                    if (i_sync) begin
                        // A draining channel nobody wants any more just stops.
                        if (state == S_RUN || i_en[k]) restart = 1'b1;
                        else stop = 1'b1;
                    end else if (wrap) begin
                        if (i_en[k]) restart = 1'b1;
                        else stop = 1'b1;
                    end else begin
                        cnt_nx   = cnt + ONE;
                        clk_nx   = (cnt + ONE) < h_act;
                        state_nx = i_en[k] ? S_RUN : S_DRAIN;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
            if (restart) begin
                state_nx = i_en[k] ? S_RUN : S_DRAIN;
                cnt_nx   = '0;
                clk_nx   = 1'b1;
                rise_nx  = 1'b1;
                if (pend) begin
                    d_act_nx = d_sh;
                    h_act_nx = h_sh;
                    pend_nx  = 1'b0;
                end
            end
            if (stop) begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
                clk_nx   = 1'b0;
            end
            if (i_load) pend_nx = 1'b1;
        end

        assign o_clk[k]     = clk_q;
        assign o_rise[k]    = rise_q;
        assign o_pending[k] = pend;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomised bench for clk_div_multi against a period-position model,
// plus literal waveform expectations for the key scenarios.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [NCH-1:0]   i_en;
    logic [NCH*W-1:0] i_div;
    logic [NCH*W-1:0] i_high;
    logic             i_load;
    logic             i_sync;
    logic [NCH-1:0]   o_clk;
    logic [NCH-1:0]   o_rise;
    logic [NCH-1:0]   o_pending;

    always #5 clk = ~clk;

    clk_div_multi #(
        .NUM_CH(NCH), .DIV_WIDTH(W), .DEF_DIV(4), .DEF_HIGH(2)
    ) dut (
        .clk(clk), .n_rst(n_rst), .i_en(i_en), .i_div(i_div),
        .i_high(i_high), .i_load(i_load), .i_sync(i_sync),
        .o_clk(o_clk), .o_rise(o_rise), .o_pending(o_pending)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    // Model: each channel is either in a period (at position pos) or not.
    int m_act[NCH];
    int m_drn[NCH];
    int m_pos[NCH];
    int m_d[NCH];
    int m_h[NCH];
    int m_sd[NCH];
    int m_sh[NCH];
    int m_pend[NCH];
    logic [NCH-1:0] e_clk, e_rise, e_pend;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void clamp(input int d, input int h,
                                  output int dc, output int hc);
        dc = (d < 2) ? 2 : d;
        hc = (h == 0) ? 1 : h;
        if (hc >= dc) hc = dc - 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_act[k] = 0; m_drn[k] = 0; m_pos[k] = 0;
            m_d[k] = 4; m_h[k] = 2; m_sd[k] = 4; m_sh[k] = 2;
            m_pend[k] = 0;
        end
        e_clk = '0; e_rise = '0; e_pend = '0;
    endtask

    task automatic model_step();
        int dc, hc;
        bit start, stop;
        for (int k = 0; k < NCH; k++) begin
            start = 0;
            stop  = 0;
            if (m_act[k] == 0) start = i_en[k];
            else if (i_sync) begin
                if (m_drn[k] == 0 || i_en[k]) start = 1;
                else stop = 1;
            end else if (m_pos[k] == m_d[k] - 1) begin
                if (i_en[k]) start = 1;
                else stop = 1;
            end else begin
                m_pos[k]++;
                m_drn[k] = !i_en[k];
            end
            if (start) begin
                if (m_pend[k] != 0) begin
                    m_d[k] = m_sd[k];
                    m_h[k] = m_sh[k];
                    m_pend[k] = 0;
                end
                m_act[k] = 1;
                m_pos[k] = 0;
                m_drn[k] = !i_en[k];
            end
            if (stop) begin
                m_act[k] = 0;
                m_pos[k] = 0;
            end
            if (i_load) begin
                clamp(int'(i_div[k*W +: W]), int'(i_high[k*W +: W]), dc, hc);
                m_sd[k] = dc;
                m_sh[k] = hc;
                m_pend[k] = 1;
            end
            e_clk[k]  = (m_act[k] != 0) && (m_pos[k] < m_h[k]);
            e_rise[k] = start;
            e_pend[k] = (m_pend[k] != 0);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            check("o_clk", 32'(o_clk), 32'(e_clk));
            check("o_rise", 32'(o_rise), 32'(e_rise));
            check("o_pending", 32'(o_pending), 32'(e_pend));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_cfg(input int k, input int d, input int h);
        i_div[k*W +: W]  = W'(d);
        i_high[k*W +: W] = W'(h);
    endtask

    task automatic load_pulse();
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
    endtask

    task automatic wait_applied(input string nm);
        int n;
        n = 0;
        while (o_pending[0] && n < 40) begin
            tick();
            n++;
        end
        check(nm, 32'(o_pending[0]), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();
        chk_on = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        i_en = '0; i_div = '0; i_high = '0;
        i_load = 1'b0; i_sync = 1'b0;
        model_reset();
        #12;
        check("rst_clk", 32'(o_clk), 32'd0);
        check("rst_rise", 32'(o_rise), 32'd0);
        check("rst_pend", 32'(o_pending), 32'd0);
        release_reset();

        // Defaults: D=4, H=2
        i_en = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("def_clk", 32'(o_clk[0]), 32'((i % 4) < 2));
            check("def_rise", 32'(o_rise[0]), 32'((i % 4) == 0));
        end

        // Load D=5,H=1 while the period sits at cnt=1
        tick();
        tick();
        set_cfg(0, 5, 1);
        load_pulse();
        check("pend_set", 32'(o_pending[0]), 32'd1);
        tick();
        check("pend_hold", 32'(o_pending[0]), 32'd1);
        check("old_period", 32'(o_clk[0]), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("d5_clk", 32'(o_clk[0]), 32'((i % 5) == 0));
            check("d5_rise", 32'(o_rise[0]), 32'((i % 5) == 0));
            if (i == 0) check("pend_clr", 32'(o_pending[0]), 32'd0);
        end

        // Back to D=4,H=2 then drop enable at cnt=0
        set_cfg(0, 4, 2);
        load_pulse();
        wait_applied("apply_d4");
        i_en = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drain_clk", 32'(o_clk[0]), 32'((i + 1) < 2));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_clk", 32'(o_clk[0]), 32'd0);
            check("idle_rise", 32'(o_rise[0]), 32'd0);
        end
        i_en = 4'b0001;
        tick();
        check("reen_clk", 32'(o_clk[0]), 32'd1);
        check("reen_rise", 32'(o_rise[0]), 32'd1);

        // Clamping
        set_cfg(0, 1, 0);
        load_pulse();
        wait_applied("apply_clamp_lo");
        for (int i = 0; i < 4; i++) begin
            check("clamp_lo", 32'(o_clk[0]), 32'((i % 2) == 0));
            tick();
        end
        set_cfg(0, 6, 9);
        load_pulse();
        wait_applied("apply_clamp_hi");
        for (int i = 0; i < 12; i++) begin
            check("clamp_hi", 32'(o_clk[0]), 32'((i % 6) < 5));
            tick();
        end

        // Two channels out of phase, then sync
        set_cfg(0, 3, 1);
        set_cfg(1, 7, 3);
        load_pulse();
        i_en = 4'b0011;
        for (int i = 0; i < 23; i++) tick();
        i_sync = 1'b1;
        tick();
        i_sync = 1'b0;
        check("sync_rise", 32'(o_rise[1:0]), 32'd3);
        check("sync_clk", 32'(o_clk[1:0]), 32'd3);
        for (int i = 1; i < 7; i++) begin
            tick();
            check("sync_ch0", 32'(o_clk[0]), 32'((i % 3) < 1));
            check("sync_ch1", 32'(o_clk[1]), 32'(i < 3));
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0)
                i_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
            i_load = ($urandom_range(0, 14) == 0);
            i_sync = ($urandom_range(0, 39) == 0);
            if (i_load) begin
                for (int k = 0; k < NCH; k++)
                    set_cfg(k, $urandom_range(0, 9), $urandom_range(0, 10));
            end
            tick();
        end
        i_load = 1'b0;
        i_sync = 1'b0;

        // Asynchronous reset in the middle of a high phase
        i_en = 4'b0001;
        set_cfg(0, 8, 6);
        load_pulse();
        wait_applied("apply_pre_rst");
        tick();
        chk_on = 1'b0;
        #2;
        check("pre_rst_high", 32'(o_clk[0]), 32'd1);
        n_rst = 1'b0;
        #1;
        check("arst_clk", 32'(o_clk), 32'd0);
        check("arst_rise", 32'(o_rise), 32'd0);
        check("arst_pend", 32'(o_pending), 32'd0);
        release_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_clk", 32'(o_clk[0]), 32'((i % 4) < 2));
            check("post_rst_rise", 32'(o_rise[0]), 32'((i % 4) == 0));
        end
        @(negedge clk);
        #1;
        chk_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel runtime-programmable clock divider, the parametrised successor to the fixed single-ratio divider. Generates NUM_CH independent divided clock-enable waveforms from one system clock, each with a programmable period and high-phase length (duty cycle). Divisor updates and channel stops take effect only at period boundaries, so no runt pulses occur. A global sync realigns all channels. Feeds peripheral bit-clock generators (UART/SPI/I2S/PWM) in the fabric.

## Interface
- NUM_CH, 4, number of independent channels
- DIV_WIDTH, 16, width of divisor, high count and per-channel counter
- DEF_DIV, 4, reset value of every channel's active divisor
- DEF_HIGH, 2, reset value of every channel's active high count
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  asynchronous active-low reset
- i_en  input  NUM_CH  per-channel run request
- i_div  input  NUM_CH*DIV_WIDTH  requested divisor D, channel k at bits [k*DIV_WIDTH +: DIV_WIDTH]
- i_high  input  NUM_CH*DIV_WIDTH  requested high-phase length H, same packing
- i_load  input  1  one-cycle strobe: capture i_div/i_high of all channels into shadow registers
- i_sync  input  1  one-cycle strobe: restart all running channels at count 0
- o_clk  output  NUM_CH  registered divided clock, one bit per channel
- o_rise  output  NUM_CH  registered one-cycle strobe in the cycle o_clk begins a period
- o_pending  output  NUM_CH  shadow settings captured but not yet active

## Operation
- Per channel: active regs D_act/H_act, shadow regs D_sh/H_sh, pending flag, counter cnt[DIV_WIDTH-1:0], state IDLE/RUN/DRAIN.
- Clamping on capture: D<2 -> D=2; H=0 -> H=1; H>=D -> H=D-1. Clamped values stored; no other arithmetic checks.
- IDLE: cnt=0, o_clk=0. If i_en[k]=1: next cycle RUN, cnt=0, o_clk=1, o_rise=1; pending shadow applied on this transition.
- RUN: cnt increments each cycle; when cnt==D_act-1, next cnt=0 (wrap) and o_rise=1. o_clk=1 iff cnt<H_act (registered with cnt, so o_clk and cnt always agree).
- At wrap: if pending, D_act/H_act <= shadow, pending cleared; the new period uses new values from cnt=0.
- i_en[k] low in RUN -> DRAIN: counting continues unchanged; at cnt==D_act-1 go IDLE (o_clk=0, no o_rise). i_en[k] high again during DRAIN -> back to RUN, no disturbance.
- i_load: all channels shadow <= clamped inputs, pending <= 1. IDLE channel: pending stays set until next IDLE->RUN. i_load while pending overwrites shadow (last load wins). i_load in same cycle as a wrap: old shadow applied at this wrap, new shadow captured and pending remains 1.
- i_sync: every RUN/DRAIN channel goes to cnt=0, o_clk=1, o_rise=1 next cycle; pending shadow applied. DRAIN channels with i_en low go to IDLE instead. IDLE channels unaffected.
- Priority: n_rst > i_sync > wrap/drain > count.
- i_sync and i_load same cycle: sync applies previous shadow (if pending); newly loaded shadow pending for next wrap.

## Timing
- Reset values: o_clk=0, o_rise=0, o_pending=0, all states IDLE, cnt=0, D_act=D_sh=DEF_DIV, H_act=H_sh=DEF_HIGH (clamped).
- Enable latency: i_en sampled high at edge N -> o_clk=1, o_rise=1 after edge N+1... i.e. visible in cycle N+1.
- Period exactly D_act clocks, high exactly H_act clocks, starting with the high phase.
- o_pending rises the cycle after i_load; falls the cycle the new settings become active.
- Reset mid-operation: all outputs 0 immediately (asynchronous), no completion of the period.

## Test plan
- Defaults (D=4,H=2), i_en[0]=1 -> o_clk[0] = 1,1,0,0 repeating; o_rise[0] every 4th cycle, first in cycle after enable.
- i_load D=5,H=1 at cnt=1 of a running period -> current 4-cycle period completes, then 1,0,0,0,0 repeating; o_pending high from load+1 until wrap.
- i_en dropped at cnt=0 (D=4) -> 3 more cycles match period, then o_clk held 0, no o_rise; re-enable -> restarts at cnt=0.
- Load D=1,H=0 then D=6,H=9 -> clamped to D=2,H=1 (1,0 pattern) and D=6,H=5 (five 1s, one 0).
- Ch0 D=3, ch1 D=7 running out of phase, i_sync -> both o_rise=1 next cycle, waveforms realigned from count 0.
- n_rst asserted mid-high-phase -> o_clk/o_rise/o_pending 0 immediately; after release active settings equal DEF_DIV/DEF_HIGH.
